buffer_ptr_ctrl: RTL

Pointer and flag controller for the circular operand buffer in the convolution engine datapath.
- Turns raw producer and consumer requests into gated write and read strobes.
- Generates W_Addr and R_Addr, and tracks the wrap (round) state.
- Derives Full, Empty, Count, and sticky error flags.
- Sits between the input streamer and feature-map consumer (upstream) and the buffer RAM (downstream).

---
 rtl/buf_pkg.sv | 21 ++
 rtl/wrap_flag.sv | 41 ++++
 rtl/buffer_ptr_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/buf_pkg.sv
// Shared constants and types for the circular operand buffer pointer logic.
package buf_pkg;

  localparam int unsigned DefaultBufferWidth = 4;

  function automatic int unsigned depth_f(input int unsigned buffer_width);
    return 32'd1 << buffer_width;
  endfunction

  function automatic int unsigned count_w_f(input int unsigned buffer_width);
    return buffer_width + 32'd1;
  endfunction

  // Error kinds, also decoded by the engine status register.
  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } err_kind_e;

endpackage

// File: rtl/wrap_flag.sv
// Lap tracker: set when the write pointer wraps ahead of the read pointer,
// cleared when the read pointer catches up by wrapping itself.
module wrap_flag #(
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [AddrW-1:0] w_addr,
  input  logic [AddrW-1:0] r_addr,
  output logic             round
);

  logic round_q;
  logic round_d;
  logic wrap_w;
  logic wrap_r;

  always_comb begin
    wrap_w  = w_en && (&w_addr);
    wrap_r  = r_en && (&r_addr);
    round_d = round_q;
    if (wrap_w && !wrap_r) begin
      round_d = 1'b1;
    end else if (wrap_r && !wrap_w) begin
      round_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      round_q <= 1'b0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round = round_q;

endmodule

// File: rtl/buffer_ptr_ctrl.sv
// Read/write pointer, occupancy flag and sticky error controller for the
// circular operand buffer. Strobes are same-cycle; state updates on the edge.
module buffer_ptr_ctrl
  import buf_pkg::*;
#(
  parameter int unsigned BufferWidth = DefaultBufferWidth
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   Push_Req,
  input  logic                   Pop_Req,
  input  logic                   Clr_Err,
  output logic                   W_En,
  output logic                   R_En,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Round,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam int unsigned Depth  = depth_f(BufferWidth);
  localparam int unsigned CountW = count_w_f(BufferWidth);

  logic [BufferWidth-1:0] w_addr_q, w_addr_d;
  logic [BufferWidth-1:0] r_addr_q, r_addr_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   round;
  logic                   ptr_eq;
  logic [CountW-1:0]      w_ext;
  logic [CountW-1:0]      r_ext;

  // Flags, strobes and next state; strobes are held low during reset.
  always_comb begin
    ptr_eq = (w_addr_q == r_addr_q);
    Empty  = ptr_eq && !round;
    Full   = ptr_eq && round;
    w_ext  = {1'b0, w_addr_q};
    r_ext  = {1'b0, r_addr_q};
    Count  = round ? (CountW'(Depth) - r_ext + w_ext) : (w_ext - r_ext);

    R_En = !aclr && Pop_Req && !Empty;
    W_En = !aclr && Push_Req && (!Full || Pop_Req);

    w_addr_d = w_addr_q + BufferWidth'(W_En);
    r_addr_d = r_addr_q + BufferWidth'(R_En);

    // A fresh rejection outranks a clear in the same cycle.
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (Clr_Err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (Push_Req && !W_En) overflow_d  = 1'b1;
    if (Pop_Req && !R_En)  underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      w_addr_q    <= '0;
      r_addr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  wrap_flag #(.AddrW(BufferWidth)) u_wrap_flag (
    .clk    (clk),
    .aclr   (aclr),
    .w_en   (W_En),
    .r_en   (R_En),
    .w_addr (w_addr_q),
    .r_addr (r_addr_q),
    .round  (round)
  );

  assign W_Addr    = w_addr_q;
  assign R_Addr    = r_addr_q;
  assign Round     = round;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

  a_full_empty_excl: assert property (@(posedge clk) disable iff (aclr) !(Full && Empty));
  a_count_bound:     assert property (@(posedge clk) disable iff (aclr) Count <= CountW'(Depth));
  a_no_push_full:    assert property (@(posedge clk) disable iff (aclr) !(W_En && Full && !Pop_Req));

endmodule
